// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: opcodes, sequencer states,
// A-register source encodings and a small decode helper.
package cpu_pkg;

    // Instruction opcodes carried in instr[7:4]
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Sequencer states, kept as plain constants so older tools accept them
    typedef logic [1:0] state_t;
    localparam state_t ST_FETCH  = 2'd0;
    localparam state_t ST_DECODE = 2'd1;
    localparam state_t ST_EXEC   = 2'd2;
    localparam state_t ST_HALT   = 2'd3;

    // A register source select
    localparam logic A_SEL_IMM = 1'b0;
    localparam logic A_SEL_ALU = 1'b1;

    // ALU function select
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Extract the opcode field of an instruction byte
    function automatic logic [3:0] opcode_of(input logic [7:0] ins);
        return ins[7:4];
    endfunction

    // Jump target: imm4 zero-extended into the 8-bit address space
    function automatic logic [7:0] jump_target(input logic [7:0] ins);
        return {4'h0, ins[3:0]};
    endfunction

endpackage

// File: rtl/program_counter.sv
// 8-bit program counter with asynchronous reset. A load takes priority
// over an increment; increment wraps modulo 256.
module program_counter #(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] pc
);

    logic [7:0] pc_q;
    logic [7:0] pc_d;

    // Next-value selection: load wins over increment, otherwise hold
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + 8'd1;
        end
    end

    // PC register, returns to PC_RESET as soon as rst rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC per instruction, with a
// terminal HALT state. ir_ce is the only Mealy strobe; all other strobes
// decode from the current state and the IR contents.
module control_unit
    import cpu_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       mem_ready,
    input  logic       zero,
    output logic [7:0] pc,
    output logic       mem_req,
    output logic       ir_ce,
    output logic       a_ce,
    output logic       b_ce,
    output logic       out_ce,
    output logic       a_sel,
    output logic       alu_sub,
    output logic       halted
);

    state_t     state_q;
    state_t     state_d;
    logic       halted_q;
    logic       pc_inc;
    logic       pc_load;
    logic [3:0] opcode;

    assign opcode = opcode_of(instr);

    // Next state and strobe decode
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        ir_ce   = 1'b0;
        a_ce    = 1'b0;
        b_ce    = 1'b0;
        out_ce  = 1'b0;
        a_sel   = A_SEL_IMM;
        alu_sub = ALU_ADD;
        pc_inc  = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                // A ready word seen while rst is high must not load the IR
                ir_ce = mem_ready & ~rst;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Gives the freshly loaded IR a cycle to reach instr
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opcode)
                    OP_LDA: begin
                        a_ce   = 1'b1;
                        a_sel  = A_SEL_IMM;
                        pc_inc = 1'b1;
                    end
                    OP_LDB: begin
                        b_ce   = 1'b1;
                        pc_inc = 1'b1;
                    end
                    OP_ADD: begin
                        a_ce    = 1'b1;
                        a_sel   = A_SEL_ALU;
                        alu_sub = ALU_ADD;
                        pc_inc  = 1'b1;
                    end
                    OP_SUB: begin
                        a_ce    = 1'b1;
                        a_sel   = A_SEL_ALU;
                        alu_sub = ALU_SUB;
                        pc_inc  = 1'b1;
                    end
                    OP_OUT: begin
                        out_ce = 1'b1;
                        pc_inc = 1'b1;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                    end
                    OP_JZ: begin
                        // zero is taken as it stands at the closing EXEC edge
                        pc_load = zero;
                        pc_inc  = ~zero;
                    end
                    OP_HLT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        // NOP and the unused opcodes 0x8-0xE
                        pc_inc = 1'b1;
                    end
                endcase
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and halted flag; halted rises on the edge that enters HALT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign halted = halted_q;

    program_counter #(
        .PC_RESET (PC_RESET)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (jump_target(instr)),
        .pc       (pc)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit plus hand-written
// sequences for halt, pc wrap and reset in the middle of EXEC.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [7:0] instr;
    logic       mem_ready;
    logic       zero;
    logic [7:0] pc;
    logic       mem_req;
    logic       ir_ce;
    logic       a_ce;
    logic       b_ce;
    logic       out_ce;
    logic       a_sel;
    logic       alu_sub;
    logic       halted;

    logic [6:0] strb_all;
    assign strb_all = {mem_req, ir_ce, a_ce, b_ce, out_ce, a_sel, alu_sub};

    int checks = 0;
    int errors = 0;
    logic [7:0] pc_prev;

    control_unit #(
        .PC_RESET (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .mem_ready (mem_ready),
        .zero      (zero),
        .pc        (pc),
        .mem_req   (mem_req),
        .ir_ce     (ir_ce),
        .a_ce      (a_ce),
        .b_ce      (b_ce),
        .out_ce    (out_ce),
        .a_sel     (a_sel),
        .alu_sub   (alu_sub),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per instruction; exp_strb = {a_ce,b_ce,out_ce,a_sel,alu_sub}
    typedef struct {
        bit         do_rst;
        int         waits;
        logic [7:0] ins;
        logic       z;
        logic [4:0] exp_strb;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Assert rst away from any clock edge and verify the reset state
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rst_pc", pc, 8'h00);
        chk("rst_halted", {7'd0, halted}, 8'd0);
        chk("rst_strobes", {1'b0, strb_all}, 8'b0100_0000);
        #2;
        mem_ready = 1'b0;
        rst       = 1'b0;
        pc_prev   = 8'h00;
    endtask

    // Drive one full instruction starting in FETCH and check every phase
    task automatic run_instr(input int waits, input logic [7:0] ins, input logic z,
                             input logic [4:0] exp_strb, input logic [7:0] exp_pc);
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            chk("wait_strobes", {1'b0, strb_all}, 8'b0100_0000);
            chk("wait_pc", pc, pc_prev);
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("fetch_strobes", {1'b0, strb_all}, 8'b0110_0000);
        chk("fetch_pc", pc, pc_prev);
        @(negedge clk);
        instr     = ins;
        mem_ready = 1'b0;
        #1;
        chk("decode_strobes", {1'b0, strb_all}, 8'd0);
        @(negedge clk);
        zero      = z;
        mem_ready = 1'b1;
        #1;
        chk("exec_strobes", {1'b0, strb_all}, {3'b000, exp_strb});
        chk("exec_pc", pc, pc_prev);
        chk("exec_halted", {7'd0, halted}, 8'd0);
        @(posedge clk);
        #1;
        chk("next_pc", pc, exp_pc);
        $display("instr=%02h zero=%0b pc %02h->%02h halted=%0b", ins, z, pc_prev, pc, halted);
        pc_prev = exp_pc;
    endtask

    initial begin
        rst       = 1'b1;
        instr     = 8'h00;
        mem_ready = 1'b0;
        zero      = 1'b0;
        pc_prev   = 8'h00;

        tbl[0]  = '{1'b1, 0, 8'h00, 1'b0, 5'b00000, 8'h01};
        tbl[1]  = '{1'b0, 5, 8'h00, 1'b0, 5'b00000, 8'h02};
        tbl[2]  = '{1'b1, 0, 8'h15, 1'b0, 5'b10000, 8'h01};
        tbl[3]  = '{1'b0, 0, 8'h23, 1'b0, 5'b01000, 8'h02};
        tbl[4]  = '{1'b0, 0, 8'h40, 1'b0, 5'b10011, 8'h03};
        tbl[5]  = '{1'b0, 0, 8'h50, 1'b0, 5'b00100, 8'h04};
        tbl[6]  = '{1'b0, 2, 8'h30, 1'b1, 5'b10010, 8'h05};
        tbl[7]  = '{1'b0, 0, 8'h6F, 1'b0, 5'b00000, 8'h0F};
        tbl[8]  = '{1'b0, 0, 8'h00, 1'b0, 5'b00000, 8'h10};
        tbl[9]  = '{1'b0, 0, 8'h7A, 1'b0, 5'b00000, 8'h11};
        tbl[10] = '{1'b0, 0, 8'h6F, 1'b0, 5'b00000, 8'h0F};
        tbl[11] = '{1'b0, 0, 8'h00, 1'b0, 5'b00000, 8'h10};
        tbl[12] = '{1'b0, 0, 8'h7A, 1'b1, 5'b00000, 8'h0A};
        tbl[13] = '{1'b0, 0, 8'h8C, 1'b1, 5'b00000, 8'h0B};
        tbl[14] = '{1'b0, 0, 8'hE3, 1'b0, 5'b00000, 8'h0C};
        tbl[15] = '{1'b0, 0, 8'h15, 1'b1, 5'b10000, 8'h0D};

        repeat (2) @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].do_rst) do_reset();
            run_instr(tbl[i].waits, tbl[i].ins, tbl[i].z, tbl[i].exp_strb, tbl[i].exp_pc);
        end

        // Halt at pc=2A: pc frozen, no strobes, mem_ready ignored, rst exits
        do_reset();
        for (int i = 0; i < 42; i++) begin
            run_instr(0, 8'h00, 1'b0, 5'b00000, pc_prev + 8'd1);
        end
        run_instr(0, 8'hF0, 1'b0, 5'b00000, 8'h2A);
        chk("halt_rise", {7'd0, halted}, 8'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = i[0];
            #1;
            chk("halt_strobes", {1'b0, strb_all}, 8'd0);
            chk("halt_pc", pc, 8'h2A);
            chk("halt_flag", {7'd0, halted}, 8'd1);
        end
        do_reset();
        run_instr(0, 8'h00, 1'b0, 5'b00000, 8'h01);

        // pc wrap from FF to 00 on NOP
        do_reset();
        for (int i = 0; i < 255; i++) begin
            run_instr(0, 8'h00, 1'b0, 5'b00000, pc_prev + 8'd1);
        end
        chk("pre_wrap_pc", pc, 8'hFF);
        run_instr(0, 8'h00, 1'b0, 5'b00000, 8'h00);

        // rst during EXEC of LDA cuts a_ce with no clock edge
        do_reset();
        run_instr(0, 8'h00, 1'b0, 5'b00000, 8'h01);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        instr     = 8'h15;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_exec_a_ce", {7'd0, a_ce}, 8'd1);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("async_rst_strobes", {1'b0, strb_all}, 8'b0100_0000);
        chk("async_rst_pc", pc, 8'h00);
        $display("async reset during LDA exec: pc=%02h a_ce=%0b", pc, a_ce);
        @(negedge clk);
        mem_ready = 1'b0;
        rst       = 1'b0;
        pc_prev   = 8'h00;
        run_instr(0, 8'h23, 1'b0, 5'b01000, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 8-bit processor. It fetches one instruction byte per instruction and decodes it into one-cycle `ce` strobes for the 8-bit storage registers (IR, A, B, OUT), ALU and mux selects, and an 8-bit program counter. It sits directly upstream of every register instance and drives each register's `ce`.

## Interface
Parameters:
- `PC_RESET`, 8'h00, program counter value after reset

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr`  in  8  current IR contents; `[7:4]` opcode, `[3:0]` imm4
- `mem_ready`  in  1  instruction memory has valid data on the IR's `d` for address `pc`
- `zero`  in  1  A register == 0, driven by the datapath
- `pc`  out  8  instruction fetch address
- `mem_req`  out  1  fetch request
- `ir_ce`  out  1  load IR
- `a_ce`  out  1  load A
- `b_ce`  out  1  load B
- `out_ce`  out  1  load OUT
- `a_sel`  out  1  A source: 0 = imm4 zero-extended, 1 = ALU result
- `alu_sub`  out  1  ALU function: 0 = A+B, 1 = A−B
- `halted`  out  1  core stopped on HLT

## Operation
States: FETCH, DECODE, EXEC, HALT.
- FETCH:
  - `mem_req`=1.
  - If `mem_ready`=1: `ir_ce`=1 combinationally in the same cycle, then go to DECODE.
  - Otherwise remain in FETCH.
- DECODE: one cycle with no strobes. This lets `instr` reflect the new IR value. Go to EXEC.
- EXEC: exactly one cycle. Strobes depend on the opcode. The next state is FETCH unless noted.
  - 0x0 NOP: none; pc+1.
  - 0x1 LDA: `a_ce`=1, `a_sel`=0; pc+1.
  - 0x2 LDB: `b_ce`=1 (B's `d` is imm4 zero-extended in the datapath); pc+1.
  - 0x3 ADD: `a_ce`=1, `a_sel`=1, `alu_sub`=0; pc+1.
  - 0x4 SUB: `a_ce`=1, `a_sel`=1, `alu_sub`=1; pc+1.
  - 0x5 OUT: `out_ce`=1; pc+1.
  - 0x6 JMP: pc ← {4'h0, imm4}.
  - 0x7 JZ: if `zero`=1, pc ← {4'h0, imm4}; otherwise pc+1. `zero` is sampled at the EXEC clock edge.
  - 0xF HLT: pc unchanged; next state is HALT.
  - 0x8–0xE: executed as NOP.
- HALT: no strobes, `halted`=1. Leaves only on `rst`.
- pc arithmetic is 8-bit modulo: 8'hFF + 1 = 8'h00, with no flag.
- All strobes are 0 outside the cases listed above. `a_sel` and `alu_sub` are 0 whenever `a_ce`=0.

## Timing
- Reset values:
  - state = FETCH
  - `pc` = PC_RESET
  - `halted` = 0
  - `mem_req` = 1, since it is combinational from FETCH
  - all `ce` strobes = 0
- `rst` asserted mid-instruction returns the block to FETCH and PC_RESET immediately, without waiting for a clock edge. Any strobe is cut asynchronously. A `mem_ready` arriving during reset is ignored.
- Minimum instruction time is 3 cycles: FETCH with `mem_ready` already high, then DECODE, then EXEC. Each cycle of `mem_ready`=0 in FETCH adds one cycle.
- `pc` is registered and updates at the end of EXEC. It stays stable through FETCH, so memory may use it as a combinational address.
- `ir_ce` is Mealy (FETCH && `mem_ready`). All other strobes are Moore: decoded from state plus `instr` only.
- Each `ce` is high for exactly one cycle per instruction.
- `halted` is registered and rises on the edge that enters HALT.
- `mem_ready` toggling during DECODE, EXEC or HALT has no effect.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (OP_NOP … OP_HLT)
  - state type (FETCH, DECODE, EXEC, HALT)
  - `a_sel` encodings
- Sub-module `program_counter`: 8-bit register with `inc`, `load` and `load_val` inputs, async reset to PC_RESET, and `load` priority over `inc`.
- FSM and decoder live in `control_unit`.

## Test plan
- Reset, then `mem_ready`=1, `instr`=8'h00 → `pc` 00→01→02; a FETCH/DECODE/EXEC cycle every 3 clocks; no `ce` other than `ir_ce`.
- Program LDA 5 (8'h15), LDB 3 (8'h23), SUB (8'h40), OUT (8'h50) → one `a_ce`, `b_ce`, `a_ce` and `out_ce` pulse in that order; `alu_sub`=1 only on the SUB EXEC; `pc`=04 after OUT.
- JZ 8'h7A executed once with `zero`=1 and once with `zero`=0, starting at `pc`=10 → next `pc` 0A when taken, 11 when not taken.
- `mem_ready` held 0 for 5 cycles in FETCH → `mem_req`=1 throughout, `ir_ce`=0, `pc` stable; `ir_ce` pulses on the first cycle `mem_ready`=1.
- HLT (8'hF0) at `pc`=2A → `halted`=1, `pc` stays 2A for 20 cycles with no strobes; asserting `rst` → `halted`=0, `pc`=00, state FETCH.
- `pc`=FF executing NOP → `pc` wraps to 00. Asserting `rst` during EXEC of LDA → `a_ce` drops without a clock edge and `pc` = PC_RESET.
